addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
Parametrised multi-cycle adder/subtractor; successor to the fixed 64-bit combinational subtractor in the ALU. Processes CHUNK bits per clock, LSB chunk first, with a registered carry chain. Trades latency for a short critical path. Uses a start/busy/done handshake and reports carry/borrow, signed overflow and zero flags. Sits in the ALU datapath behind the operand latches.

Parameters:
WIDTH, 64, operand/result width in bits
CHUNK, 16, bits processed per cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise)
NCHUNK, WIDTH/CHUNK, derived (localparam), cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when not busy
sub  input  1  0 = add, 1 = subtract; latched at start
a  input  WIDTH  operand A; latched at start
b  input  WIDTH  operand B; latched at start
c_in  input  1  carry-in (add) / borrow-in (sub); latched at start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: result and flags valid
result  output  WIDTH  sum/difference, held until next accepted start
carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow, 0 = borrow
overflow  output  1  two's-complement signed overflow
zero  output  1  result == 0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: all state clears immediately, independent of clk. State = IDLE; busy, done, result, carry_out, overflow, zero = 0; internal chunk counter and carry = 0. Reset mid-operation aborts it and produces no done.
- Arithmetic:
  - add: {carry_out, result} = a + b + c_in.
  - sub: a - b - c_in, computed as a + ~b + ~c_in. carry_out is the raw carry out of the MSB.
  - overflow: for the effective B operand b' (b for add, ~b for sub), overflow = (a[MSB] == b'[MSB]) && (result[MSB] != a[MSB]).
  - All sums wrap modulo 2^WIDTH.
- FSM states: IDLE, RUN.
  - IDLE & start: latch a, b' and c_in' (c_in for add, ~c_in for sub) into the working carry register. Clear the counter, set busy=1, go to RUN.
  - IDLE & !start: hold.
  - RUN: each edge adds chunk[cnt] of a and b' plus the carry register. The chunk sum is written into result[cnt*CHUNK +: CHUNK], the carry register updates, and cnt increments.
  - RUN, last chunk (cnt == NCHUNK-1): write carry_out, overflow and zero. Set busy=0, done=1 for exactly one cycle, go to IDLE.
- Latency: start sampled at edge 0 gives done=1 after edge NCHUNK. NCHUNK=1 gives 1-cycle latency.
- Intermediate values: result bits above the current chunk are undefined to consumers while busy. Only sample result and flags when done=1 or while idle after done.
- start while busy: ignored. Operands are not re-latched and the in-flight operation is unaffected.
- start in the cycle done=1: accepted (state is IDLE), giving back-to-back operations with no bubble. The previous result stays visible in that cycle.
- Flags and result hold their values through IDLE until the next operation's done cycle overwrites them. The first RUN edge clears zero, overflow and carry_out.
- Input changes on a, b, sub, c_in while busy have no effect.

Test Plan:
1. Defaults. sub=1, a=738468, b=900000, c_in=0 -> after 4 cycles, done=1. result=0xFFFFFFFFFFFD8904 (-161532), carry_out=0, overflow=0, zero=0. Then sub=1, a=7446525, b=1000000 -> result=6446525, carry_out=1, overflow=0.
2. Overflow.
   - add a=0x7FFFFFFFFFFFFFFF, b=1 -> result=0x8000000000000000, overflow=1, carry_out=0.
   - sub a=0x8000000000000000, b=1 -> result=0x7FFFFFFFFFFFFFFF, overflow=1, carry_out=1.
3. Carry/zero/c_in.
   - add a=0xFFFFFFFFFFFFFFFF, b=1, c_in=0 -> result=0, carry_out=1, zero=1.
   - sub a=10, b=3, c_in=1 -> result=6, carry_out=1.
   - sub a=b=12345 -> zero=1, carry_out=1.
4. Handshake.
   - Pulse start again 2 cycles into an operation with different operands -> first result unchanged, single done.
   - Assert start in the done cycle -> second done exactly 4 cycles later with correct result.
5. Reset mid-operation. Assert rst asynchronously (between edges) at cycle 2 -> busy, done, result and flags read 0 immediately; no done follows. A new start after release computes correctly.
6. Parameter sweep.
   - WIDTH=8, CHUNK=8: add 0x7F+0x01 -> done 1 cycle after start, result=0x80, overflow=1.
   - WIDTH=32, CHUNK=4: random add/sub vs reference model, latency 8.

Source files
------------

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor. Works through the operands
// CHUNK bits per clock, LSB chunk first, keeping the inter-chunk carry in a
// register so the critical path is one CHUNK-bit adder. It reports
// carry/borrow, signed overflow and zero with a start/busy/done handshake.
module addsub_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    // A partial top chunk would silently drop operand bits, so refuse to build.
    generate
        if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
            $error("addsub_seq: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Two's-complement overflow: both addends share a sign and the sum does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q;        // latched operand A
    logic [WIDTH-1:0] b_q;        // latched effective operand B (inverted for sub)
    logic             carry_q;    // carry into the chunk being processed
    logic [CNT_W-1:0] cnt;        // index of the chunk being processed
    logic             zero_acc;   // all chunks written so far were zero
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;

    // Chunk adder: current slice of A and B' plus the registered carry.
    always_comb begin
        a_chunk    = a_q[cnt*CHUNK +: CHUNK];
        b_chunk    = b_q[cnt*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (cnt == LAST_CNT);
    end

    // Next-state logic: IDLE waits for start, RUN lasts exactly NCHUNK edges.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign busy = (state == RUN);

    // Operand latch, chunk-by-chunk result write and flag update on the last chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            zero_acc  <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a_q      <= a;
                    b_q      <= sub ? ~b : b;
                    carry_q  <= sub ^ c_in;   // borrow-in becomes inverted carry-in
                    cnt      <= '0;
                    zero_acc <= 1'b1;
                end
            end else begin
                result[cnt*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                carry_q  <= chunk_sum[CHUNK];
                zero_acc <= zero_acc & (chunk_sum[CHUNK-1:0] == '0);
                cnt      <= cnt + 1'b1;
                if (last_chunk) begin
                    carry_out <= chunk_sum[CHUNK];
                    overflow  <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], chunk_sum[CHUNK-1]);
                    zero      <= zero_acc & (chunk_sum[CHUNK-1:0] == '0);
                    done      <= 1'b1;
                    cnt       <= '0;
                end else if (cnt == '0) begin
                    // Stale flags from the previous operation are dropped on the first chunk.
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq at 64/16, 8/8 and 32/4.
module tb_addsub_seq;

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q64[$];
    exp_t q8[$];
    exp_t q32[$];

    // 64/16 instance
    logic        start, sub, c_in, busy, done, carry_out, overflow, zero;
    logic [63:0] a, b, result;
    // 8/8 instance
    logic        start8, sub8, cin8, busy8, done8, co8, ov8, z8;
    logic [7:0]  a8, b8, res8;
    // 32/4 instance
    logic        start32, sub32, cin32, busy32, done32, co32, ov32, z32;
    logic [31:0] a32, b32, res32;

    addsub_seq #(.WIDTH(64), .CHUNK(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    addsub_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .result(res8), .carry_out(co8),
        .overflow(ov8), .zero(z8)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(4)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32), .c_in(cin32),
        .busy(busy32), .done(done32), .result(res32), .carry_out(co32),
        .overflow(ov32), .zero(z32)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic unexpected_done(input string nm);
        checks++;
        errors++;
        $display("FAIL %s done=1 with no operation outstanding, expected no done (t=%0t)", nm, $time);
    endtask

    function automatic logic sel_busy(input int w);
        case (w)
            0:       return busy;
            1:       return busy8;
            default: return busy32;
        endcase
    endfunction

    task automatic wait_idle(input int which);
        int   n;
        logic bz;
        n  = 0;
        bz = sel_busy(which);
        while (bz && n < 100) begin
            @(negedge clk);
            n++;
            bz = sel_busy(which);
        end
        if (bz) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d busy=1 after %0d cycles, expected 0", which, n);
        end
    endtask

    // Called at a negedge; the next posedge is the start edge.
    task automatic issue64(input logic s, input logic [63:0] ia, input logic [63:0] ib,
                           input logic ci, input logic [63:0] er, input logic ec,
                           input logic ev, input logic ez, input bit do_wait);
        sub = s; a = ia; b = ib; c_in = ci; start = 1'b1;
        q64.push_back('{er, ec, ev, ez, cyc + 1 + 4});
        @(negedge clk);
        start = 1'b0;
        if (do_wait) wait_idle(0);
    endtask

    task automatic issue8(input logic s, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ci, input logic [7:0] er, input logic ec,
                          input logic ev, input logic ez);
        sub8 = s; a8 = ia; b8 = ib; cin8 = ci; start8 = 1'b1;
        q8.push_back('{{56'd0, er}, ec, ev, ez, cyc + 1 + 1});
        @(negedge clk);
        start8 = 1'b0;
        wait_idle(1);
    endtask

    task automatic issue32(input logic s, input logic [31:0] ia, input logic [31:0] ib,
                           input logic ci, input logic [31:0] er, input logic ec,
                           input logic ev, input logic ez);
        sub32 = s; a32 = ia; b32 = ib; cin32 = ci; start32 = 1'b1;
        q32.push_back('{{32'd0, er}, ec, ev, ez, cyc + 1 + 8});
        @(negedge clk);
        start32 = 1'b0;
        wait_idle(2);
    endtask

    // Monitor for the 64-bit instance.
    exp_t e64;
    always @(negedge clk) begin
        if (done) begin
            if (q64.size() == 0) unexpected_done("done64");
            else begin
                e64 = q64.pop_front();
                chk("result64", result, e64.res);
                chk("carry64", {63'd0, carry_out}, {63'd0, e64.c});
                chk("ovf64", {63'd0, overflow}, {63'd0, e64.v});
                chk("zero64", {63'd0, zero}, {63'd0, e64.z});
                chk("latency64", 64'(cyc), 64'(e64.due));
            end
        end
    end

    // Monitor for the 8-bit instance.
    exp_t e8;
    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) unexpected_done("done8");
            else begin
                e8 = q8.pop_front();
                chk("result8", {56'd0, res8}, e8.res);
                chk("carry8", {63'd0, co8}, {63'd0, e8.c});
                chk("ovf8", {63'd0, ov8}, {63'd0, e8.v});
                chk("zero8", {63'd0, z8}, {63'd0, e8.z});
                chk("latency8", 64'(cyc), 64'(e8.due));
            end
        end
    end

    // Monitor for the 32-bit instance.
    exp_t e32;
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) unexpected_done("done32");
            else begin
                e32 = q32.pop_front();
                chk("result32", {32'd0, res32}, e32.res);
                chk("carry32", {63'd0, co32}, {63'd0, e32.c});
                chk("ovf32", {63'd0, ov32}, {63'd0, e32.v});
                chk("zero32", {63'd0, z32}, {63'd0, e32.z});
                chk("latency32", 64'(cyc), 64'(e32.due));
            end
        end
    end

    initial begin
        start = 0; sub = 0; a = '0; b = '0; c_in = 0;
        start8 = 0; sub8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start32 = 0; sub32 = 0; a32 = '0; b32 = '0; cin32 = 0;

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_carry", {63'd0, carry_out}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic subtraction, borrow and no-borrow.
        issue64(1, 64'd738468, 64'd900000, 0, 64'hFFFF_FFFF_FFFD_8904, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        issue64(1, 64'd7446525, 64'd1000000, 0, 64'd6446525, 1, 0, 0, 1);
        // Overflow cases (issued back-to-back in the done cycle).
        issue64(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 0, 1, 0, 1);
        issue64(1, 64'h8000_0000_0000_0000, 64'd1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 1);
        // Carry, zero and carry/borrow-in.
        issue64(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0, 1, 0, 1, 1);
        issue64(1, 64'd10, 64'd3, 1, 64'd6, 1, 0, 0, 1);
        issue64(1, 64'd12345, 64'd12345, 0, 64'd0, 1, 0, 1, 1);
        issue64(0, 64'd5, 64'd7, 1, 64'd13, 0, 0, 0, 1);

        // Start pulsed 2 cycles into an operation must be ignored.
        issue64(0, 64'd1000, 64'd234, 0, 64'd1234, 0, 0, 0, 0);
        @(negedge clk);
        sub = 1; a = 64'hDEAD_BEEF; b = 64'h1234; c_in = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(0);
        repeat (6) @(negedge clk);

        // Reset between edges mid-operation: no done may follow.
        sub = 0; a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; c_in = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_result", result, 64'd0);
        chk("midrst_carry", {63'd0, carry_out}, 64'd0);
        chk("midrst_ovf", {63'd0, overflow}, 64'd0);
        chk("midrst_zero", {63'd0, zero}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("postrst_busy", {63'd0, busy}, 64'd0);
        issue64(0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 0,
                64'h1234_5678_9ABC_DF00, 0, 0, 0, 1);

        // Single-chunk instance: 1-cycle latency.
        issue8(0, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 0);
        issue8(1, 8'h00, 8'h01, 0, 8'hFF, 0, 0, 0);
        issue8(0, 8'h80, 8'h80, 0, 8'h00, 1, 1, 1);

        // 4-bit chunks: carries ripple through eight registered stages.
        issue32(0, 32'h0000_FFFF, 32'h0000_0001, 0, 32'h0001_0000, 0, 0, 0);
        issue32(1, 32'h1234_5678, 32'h1234_5679, 0, 32'hFFFF_FFFF, 0, 0, 0);
        issue32(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1, 0, 0);
        issue32(1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 32'h0000_0001, 1, 1, 0);

        repeat (12) @(negedge clk);
        chk("pending64", 64'(q64.size()), 64'd0);
        chk("pending8", 64'(q8.size()), 64'd0);
        chk("pending32", 64'(q32.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
